// File: rtl/frame_loader_pkg.sv
// Shared constants and state encoding for the DMD frame loader.
// Geometry: 128x32 4-bit pixels. One frame fills a 4096-entry bank and arrives as 2048 bytes.
// The wire protocol is a sync byte, then a command byte, then the payload.
package frame_loader_pkg;

   localparam int          DMD_FRAME_W      = 128;
   localparam int          DMD_FRAME_H      = 32;
   localparam int          PIXELS_PER_FRAME = 4096;
   localparam int          BYTES_PER_FRAME  = 2048;
   localparam logic [7:0]  DMD_SYNC_BYTE    = 8'hA5;
   localparam logic [7:0]  CMD_FRAME        = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CMD       = 3'd1,
      ST_DATA      = 3'd2,
      ST_WR_HI     = 3'd3,
      ST_WR_LO     = 3'd4,
      ST_WAIT_SWAP = 3'd5
   } state_t;

endpackage

// File: rtl/frame_loader_if.sv
// Byte stream in and frame-buffer write port out, bundled into one interface.
// Ports: rx_data/rx_valid come from the UART receiver as a one-cycle strobe.
// Ports: wr_en/wr_addr/wr_data drive the BRAM write side. slave = loader, master = source/sink.
interface frame_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [3:0]  wr_data;

   modport slave  (input  rx_data, rx_valid, output wr_en, wr_addr, wr_data);
   modport master (output rx_data, rx_valid, input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/frame_loader_rx_skid_buf.sv
// One-entry byte holder. It catches a byte that arrives while the loader is busy writing.
// Latency: a stored byte is visible on dout the cycle after push. Pop and push in the same cycle replace it.
// Backpressure: none. A push while full and not popping drops the byte and pulses overflow. Ports: clk, rst, flush, push, pop, din, dout, full, overflow.
module rx_skid_buf (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       overflow
);

   logic [7:0] data_q, data_d;
   logic       full_q, full_d;

   always_comb begin
      data_d   = data_q;
      full_d   = full_q;
      overflow = 1'b0;
      if (flush) begin
         full_d = 1'b0;
      end else if (push && (!full_q || pop)) begin
         data_d = din;
         full_d = 1'b1;
      end else if (push) begin
         overflow = 1'b1;
      end else if (pop) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign dout = data_q;
   assign full = full_q;

endmodule

// File: rtl/frame_loader.sv
// Parses UART frames into the back bank of the DMD frame buffer and swaps banks on vsync.
// Latency: a byte taken in DATA gives the hi-nibble write next cycle and the lo-nibble write the cycle after. All outputs are registered.
// Backpressure: none. One early byte is buffered; further early bytes, bytes during WAIT_SWAP, bad commands and timeouts pulse err.
// Ports: clk, rst (sync, active-high), bus (rx in / BRAM write out), vsync, disp_bank, frame_done, err, busy.
module frame_loader
   import frame_loader_pkg::*;
#(
   parameter int         FRAME_W     = DMD_FRAME_W,
   parameter int         FRAME_H     = DMD_FRAME_H,
   parameter logic [7:0] SYNC_BYTE   = DMD_SYNC_BYTE,
   parameter int         TIMEOUT_CYC = 1000000
) (
   input  logic           clk,
   input  logic           rst,
   frame_loader_if.slave  bus,
   input  logic           vsync,
   output logic           disp_bank,
   output logic           frame_done,
   output logic           err,
   output logic           busy
);

   // Index of the even pixel in the last pair of the frame.
   localparam logic [11:0]  LAST_PAIR = 12'(FRAME_W * FRAME_H - 2);
   localparam int           TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   state_t          state_q, state_d;
   logic [11:0]     idx_q, idx_d;
   logic [3:0]      lo_nib_q, lo_nib_d;
   logic            disp_q, disp_d;
   logic            vsync_q;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            wr_en_q, wr_en_d;
   logic [12:0]     wr_addr_q, wr_addr_d;
   logic [3:0]      wr_data_q, wr_data_d;
   logic            frame_done_q, frame_done_d;
   logic            err_q, err_d;

   logic            skid_flush, skid_push, skid_pop;
   logic [7:0]      skid_dout;
   logic            skid_full, skid_ovf;
   logic            have_byte;
   logic [7:0]      in_byte;
   logic            stall;

   rx_skid_buf u_skid (
      .clk      (clk),
      .rst      (rst),
      .flush    (skid_flush),
      .push     (skid_push),
      .pop      (skid_pop),
      .din      (bus.rx_data),
      .dout     (skid_dout),
      .full     (skid_full),
      .overflow (skid_ovf)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      lo_nib_d     = lo_nib_q;
      disp_d       = disp_q;
      tmo_d        = '0;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      err_d        = skid_ovf;
      skid_flush   = 1'b0;
      skid_push    = 1'b0;
      skid_pop     = 1'b0;
      have_byte    = 1'b0;
      in_byte      = bus.rx_data;
      stall        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            skid_flush = 1'b1;
            if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_d = ST_CMD;
         end
         ST_CMD: begin
            skid_flush = 1'b1;
            if (bus.rx_valid) begin
               if (bus.rx_data == CMD_FRAME) begin
                  state_d = ST_DATA;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               stall = 1'b1;
            end
         end
         ST_DATA: begin
            // A buffered byte is older than anything on the wire, so it goes first.
            // A byte arriving in the same cycle refills the buffer.
            if (skid_full) begin
               skid_pop  = 1'b1;
               skid_push = bus.rx_valid;
               in_byte   = skid_dout;
               have_byte = 1'b1;
            end else if (bus.rx_valid) begin
               have_byte = 1'b1;
            end
            if (have_byte) begin
               lo_nib_d  = in_byte[3:0];
               wr_en_d   = 1'b1;
               wr_addr_d = {~disp_q, idx_q};
               wr_data_d = in_byte[7:4];
               state_d   = ST_WR_HI;
            end else begin
               stall = 1'b1;
            end
         end
         ST_WR_HI: begin
            skid_push = bus.rx_valid;
            wr_en_d   = 1'b1;
            wr_addr_d = {~disp_q, idx_q + 12'd1};
            wr_data_d = lo_nib_q;
            state_d   = ST_WR_LO;
         end
         ST_WR_LO: begin
            skid_push = bus.rx_valid;
            if (idx_q == LAST_PAIR) begin
               frame_done_d = 1'b1;
               state_d      = ST_WAIT_SWAP;
            end else begin
               idx_d   = idx_q + 12'd2;
               state_d = ST_DATA;
            end
         end
         ST_WAIT_SWAP: begin
            skid_flush = 1'b1;
            if (bus.rx_valid) err_d = 1'b1;
            // Only an edge seen while already waiting counts. An edge on the entry cycle is ignored.
            if (vsync && !vsync_q) begin
               disp_d  = ~disp_q;
               idx_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The idle counter runs only while the loader waits on the host mid-frame.
      if (stall) begin
         if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         lo_nib_q     <= '0;
         disp_q       <= 1'b0;
         vsync_q      <= 1'b0;
         tmo_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         lo_nib_q     <= lo_nib_d;
         disp_q       <= disp_d;
         vsync_q      <= vsync;
         tmo_q        <= tmo_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign disp_bank   = disp_q;
   assign frame_done  = frame_done_q;
   assign err         = err_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Sequences the write side of the 4-bit grayscale DMD frame buffer (128x32 pixels, 13-bit address = two 4096-pixel banks).
- Parses the UART byte stream into frames and writes them into the back bank.
- Swaps front/back bank at the next vertical-sync rising edge, so the video scan-out never shows a partially loaded frame.
- Sits between async_receiver and the frame-buffer BRAM write port; disp_bank drives the top address bit of the read side.

Parameters:
FRAME_W, 128, pixels per line
FRAME_H, 32, lines per frame
SYNC_BYTE, 8'hA5, frame-start marker
TIMEOUT_CYC, 1000000, idle clk cycles allowed mid-frame before abort

Ports:
clk  in  1  system clock, same as video timing
rst  in  1  synchronous, active-high reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
vsync  in  1  registered vSync from video timing
wr_en  out  1  BRAM write enable
wr_addr  out  13  {bank, pixel_index[11:0]}, pixel_index = y*128 + x
wr_data  out  4  pixel intensity
disp_bank  out  1  bank currently displayed
frame_done  out  1  one-cycle pulse, frame fully written
err  out  1  one-cycle pulse on protocol error, timeout or overflow
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; pixel_index 0; swap flag 0. Reset mid-frame abandons the frame without a swap.
- Protocol: SYNC_BYTE, then CMD byte, then payload.
  - CMD 8'h01: 2048 payload bytes, each = two pixels. High nibble = even pixel, low nibble = following odd pixel.
  - Any other CMD: err pulse, return to IDLE.
- States:
  - IDLE: hunt for SYNC_BYTE; other bytes dropped silently.
  - CMD: next byte; 8'h01 -> DATA, else error -> IDLE.
  - DATA: wait for a byte, latch it -> WR_HI.
  - WR_HI: wr_en=1, wr_addr={~disp_bank, idx}, wr_data=byte[7:4] -> WR_LO.
  - WR_LO: wr_en=1, addr idx+1, data byte[3:0]. If idx+1 == 4095: frame_done pulse next cycle, -> WAIT_SWAP; else idx += 2, -> DATA.
  - WAIT_SWAP: on vsync rising edge (vsync & ~vsync_d), toggle disp_bank, reset idx to 0 -> IDLE.
- Latency: byte strobed in cycle N (in DATA) -> hi write in N+1, lo write in N+2. All write outputs are registered.
- One-entry skid register (rx_skid_buf):
  - A byte arriving during WR_HI/WR_LO is held and consumed on return to DATA.
  - A second byte arriving while the skid is full: err pulse, that byte dropped, frame continues.
- Bytes arriving in WAIT_SWAP are dropped with an err pulse; the host must pace frames to ≤1 per video frame.
- Timeout: counter clears on every rx_valid in CMD/DATA. On reaching TIMEOUT_CYC: err pulse, -> IDLE, idx=0, no swap, disp_bank unchanged.
- Vsync rising edge in the same cycle as entry to WAIT_SWAP is not honoured; the swap waits for the next rising edge.
- SYNC_BYTE value inside the payload is ordinary data; no resync mid-frame.
- The back bank is written only while disp_bank is stable; disp_bank changes only in WAIT_SWAP on the vsync edge.

Decomposition:
- Shared header lcd_dmd_defs.vh:
  - FRAME_W, FRAME_H
  - PIXELS_PER_FRAME=4096, BYTES_PER_FRAME=2048
  - SYNC_BYTE, CMD_FRAME=8'h01
  - state encodings
- One sub-module, rx_skid_buf: one-entry byte buffer with full flag and overflow pulse.
- Vsync edge detect and timeout counter stay inline.

Test Plan:
- Reset, then A5 01 followed by 2048 bytes of 8'h3C:
  - 4096 writes to addresses 4096..8191, data alternating 3,C.
  - frame_done pulse once.
  - disp_bank 0->1 on the next vsync rise.
- Two back-to-back frames (first all 8'h11, second all 8'h22, each preceded by vsync):
  - second frame written to addresses 0..4095.
  - disp_bank returns to 0.
- A5 07:
  - err pulse one cycle after 07.
  - no wr_en.
  - state IDLE; a following A5 01 is accepted.
- Stall after 100 payload bytes for TIMEOUT_CYC+1 cycles:
  - err pulse; busy falls.
  - disp_bank unchanged.
  - a fresh frame restarts at pixel_index 0.
- rx_valid on three consecutive cycles in DATA:
  - bytes 1 and 2 written correctly in order (byte 2 via skid).
  - byte 3 dropped with err pulse.
- Bytes sent during WAIT_SWAP: err per byte, no writes. Assert rst mid-frame: all outputs 0 the next cycle, disp_bank 0.
